// File: rtl/gray2bin_pkg.sv
// Shared constants and types for the Gray-to-binary round-robin arbiter.
// Imported by the conversion core and the arbiter top.
package gray2bin_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 16;

    // Saturation value of the default-width transfer counter
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Width of a requester index
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/gray_to_binary_core.sv
// Combinational Gray-to-binary chain.
// The MSB passes through; each lower bit XORs with the bit above it.
module gray_to_binary_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [WIDTH-1:0] b;

    // Ripple the XOR prefix from MSB down to LSB
    always_comb begin
        b = '0;
        b[WIDTH-1] = gray_i[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ gray_i[k];
        end
    end

    assign bin_o = b;

endmodule

// File: rtl/gray2bin_rr_arbiter.sv
// Round-robin share of one Gray-to-binary converter among NUM_REQ sources.
// Registered output stage with valid/ready backpressure and source tag.
module gray2bin_rr_arbiter
    import gray2bin_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_gray,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_bin,
    output logic [ID_W-1:0]          out_id,
    output logic [CNT_W-1:0]         conv_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

    out_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_bin_q, out_bin_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [CNT_W-1:0] conv_count_q, conv_count_d;

    logic             found;
    logic [ID_W-1:0]  grant_id;
    logic             can_accept;
    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] win_gray;
    logic [WIDTH-1:0] win_bin;

    assign out_valid  = (state_q == FULL);
    assign can_accept = !out_valid || out_ready;
    assign drain      = out_valid && out_ready;

    // Pick the first valid requester at or after the pointer
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found    = 1'b1;
                grant_id = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // One-hot accept strobe, suppressed in reset and under backpressure
    always_comb begin
        req_ready = '0;
        if (found && can_accept && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept   = |req_ready;
    assign win_gray = req_gray[int'(grant_id)*WIDTH +: WIDTH];

    gray_to_binary_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .gray_i (win_gray),
        .bin_o  (win_bin)
    );

    // Next-state for output stage, pointer and transfer counter
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        out_bin_d    = out_bin_q;
        out_id_d     = out_id_q;
        conv_count_d = conv_count_q;
        if (accept) begin
            state_d   = FULL;
            out_bin_d = win_bin;
            out_id_d  = grant_id;
            rr_ptr_d  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end else if (drain) begin
            state_d = EMPTY;
        end
        if (drain && conv_count_q != CNT_MAX) begin
            conv_count_d = conv_count_q + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            rr_ptr_q     <= '0;
            out_bin_q    <= '0;
            out_id_q     <= '0;
            conv_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            out_bin_q    <= out_bin_d;
            out_id_q     <= out_id_d;
            conv_count_q <= conv_count_d;
        end
    end

    assign out_bin    = out_bin_q;
    assign out_id     = out_id_q;
    assign conv_count = conv_count_q;

endmodule

// File: tb/tb_gray2bin_rr_arbiter.sv
// Directed bench for gray2bin_rr_arbiter.
// A second instance with a 4-bit counter covers saturation.
module tb_gray2bin_rr_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_gray;
    logic           out_ready;

    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_bin;
    logic [IW-1:0]  out_id;
    logic [15:0]    conv_count;

    logic [N-1:0]   s_req_ready;
    logic           s_out_valid;
    logic [W-1:0]   s_out_bin;
    logic [IW-1:0]  s_out_id;
    logic [3:0]     s_conv_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray2bin_rr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bin    (out_bin),
        .out_id     (out_id),
        .conv_count (conv_count)
    );

    gray2bin_rr_arbiter #(.CNT_W(4)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (s_req_ready),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_bin    (s_out_bin),
        .out_id     (s_out_id),
        .conv_count (s_conv_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string nm, input logic [N-1:0] exp);
        #1;
        total++;
        if (req_ready !== exp) begin
            bad++;
            $display("FAIL %s req_ready got=%b want=%b", nm, req_ready, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v,
                           input logic [W-1:0] b, input logic [IW-1:0] id);
        total++;
        if (out_valid !== v || out_bin !== b || out_id !== id) begin
            bad++;
            $display("FAIL %s got v=%b bin=%h id=%0d want v=%b bin=%h id=%0d",
                     nm, out_valid, out_bin, out_id, v, b, id);
        end
    endtask

    task automatic chk_cnt(input string nm, input logic [15:0] exp);
        total++;
        if (conv_count !== exp) begin
            bad++;
            $display("FAIL %s conv_count got=%0d want=%0d", nm, conv_count, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_gray  = 32'h0804_0201;
        out_ready = 1'b0;
        chk_ready("reset_ready", 4'b0000);
        tick();
        chk_out("reset_out", 1'b0, 8'h00, 2'd0);
        chk_cnt("reset_cnt", 16'd0);
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single();
        req_valid       = 4'b0001;
        req_gray[7:0]   = 8'hFF;
        out_ready       = 1'b1;
        chk_ready("single_ready", 4'b0001);
        tick();
        chk_out("single_out", 1'b1, 8'hAA, 2'd0);
        req_valid        = 4'b0101;
        req_gray[23:16]  = 8'h00;
        chk_ready("single_ptr1", 4'b0100);
        req_valid = '0;
        #1;
        tick();
        chk_out("single_drain", 1'b0, 8'hAA, 2'd0);
        chk_cnt("single_cnt", 16'd1);
    endtask

    task automatic test_sweep();
        logic [W-1:0] g [4];
        logic [W-1:0] b [4];
        g = '{8'h80, 8'hC0, 8'h03, 8'h00};
        b = '{8'hFF, 8'h80, 8'h02, 8'h00};
        req_valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            req_gray[23:16] = g[i];
            chk_ready($sformatf("sweep_ready%0d", i), 4'b0100);
            tick();
            chk_out($sformatf("sweep_out%0d", i), 1'b1, b[i], 2'd2);
        end
        req_valid = '0;
        tick();
        chk_out("sweep_drain", 1'b0, 8'h00, 2'd2);
        chk_cnt("sweep_cnt", 16'd5);
    endtask

    task automatic test_round_robin();
        logic [W-1:0] b [4];
        b = '{8'h01, 8'h03, 8'h07, 8'h0F};
        do_reset();
        out_ready = 1'b1;
        req_gray  = 32'h0804_0201;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            chk_ready($sformatf("rr_ready%0d", i), 4'(1 << (i % 4)));
            tick();
            chk_out($sformatf("rr_out%0d", i), 1'b1, b[i % 4], 2'(i % 4));
        end
        req_valid = '0;
        tick();
        chk_cnt("rr_cnt5", 16'd5);
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0001;
        out_ready = 1'b1;
        tick();
        chk_out("bp_fill", 1'b1, 8'h01, 2'd0);
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            chk_ready($sformatf("bp_ready%0d", i), 4'b0000);
            tick();
            chk_out($sformatf("bp_hold%0d", i), 1'b1, 8'h01, 2'd0);
        end
        out_ready = 1'b1;
        req_valid = 4'b1000;
        chk_ready("bp_release", 4'b1000);
        tick();
        chk_out("bp_reload", 1'b1, 8'h0F, 2'd3);
        chk_cnt("bp_cnt", 16'd6);
        req_valid = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst       = 1'b1;
        req_valid = 4'b1111;
        chk_ready("rmid_ready", 4'b0000);
        tick();
        chk_out("rmid_out", 1'b0, 8'h00, 2'd0);
        chk_cnt("rmid_cnt", 16'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        chk_ready("rmid_first", 4'b0001);
        tick();
        chk_out("rmid_grant", 1'b1, 8'h01, 2'd0);
        req_valid = '0;
        tick();
    endtask

    task automatic test_saturation();
        logic [3:0] exp;
        do_reset();
        out_ready     = 1'b1;
        req_gray[7:0] = 8'h01;
        req_valid     = 4'b0001;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp = (k - 1 > 15) ? 4'hF : 4'(k - 1);
            total++;
            if (s_conv_count !== exp) begin
                bad++;
                $display("FAIL sat_step%0d conv_count got=%0d want=%0d",
                         k, s_conv_count, exp);
            end
        end
        req_valid = '0;
        tick();
        total++;
        if (s_conv_count !== 4'hF) begin
            bad++;
            $display("FAIL sat_final conv_count got=%0d want=15", s_conv_count);
        end
        chk_cnt("sat_wide", 16'd17);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_gray  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_sweep();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray2bin_rr_arbiter.md
Name: gray2bin_rr_arbiter

Overview:
- Shares one WIDTH-bit Gray-to-binary conversion datapath among NUM_REQ requesters.
- Round-robin arbitration over per-requester valid/ready inputs.
- Result held in a single registered output stage with valid/ready backpressure, tagged with the requester index.
- Sits between the Gray-coded sources (counters, encoder feeds) and the binary consumer, replacing per-source converters.

Parameters:
- WIDTH, 8, bit width of Gray input and binary output.
- NUM_REQ, 4, number of requesters; must be ≥2.
- ID_W, $clog2(NUM_REQ), width of requester index (derived; not overridden).
- CNT_W, 16, width of the saturating conversion counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_gray  input  NUM_REQ*WIDTH  packed Gray words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot (or zero) accept strobe, combinational.
- out_valid  output  1  registered result valid.
- out_ready  input  1  consumer accepts result.
- out_bin  output  WIDTH  registered binary result.
- out_id  output  ID_W  index of the requester that produced out_bin.
- conv_count  output  CNT_W  number of completed output transfers, saturating.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_bin=0, out_id=0, conv_count=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 during the reset cycle.
- Conversion rule:
  - B[WIDTH-1] = G[WIDTH-1].
  - B[k] = B[k+1] XOR G[k] for k = WIDTH-2 down to 0.
  - Purely combinational in the shared core.
- Output stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - can_accept = !out_valid || out_ready.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - First i with req_valid[i]=1 wins.
  - req_ready[i]=1 only when can_accept=1, rr_ptr is otherwise unaffected, and rst=0; all other req_ready bits are 0.
- Accept (handshake req_valid[g] && req_ready[g]):
  - Next edge: out_bin <= convert(req_gray[g]), out_id <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 result per cycle while out_ready is held high.
- Drain: out_valid && out_ready with no new accept → out_valid <= 0. out_bin and out_id keep their last values.
- Simultaneous drain + accept in the same cycle: output reloads with the new result and out_valid stays 1 (no bubble).
- Backpressure:
  - out_valid && !out_ready → all req_ready=0.
  - out_bin, out_id, out_valid held stable.
  - rr_ptr unchanged.
- No requests: rr_ptr unchanged; output follows the drain rule.
- conv_count:
  - Increments on each output transfer (out_valid && out_ready).
  - Saturates at 2^CNT_W−1; no wrap.
- rr_ptr wraps from NUM_REQ−1 to 0.
- Requester protocol:
  - Requester must hold req_valid and req_gray stable until its req_ready.
  - Dropping req_valid before grant is permitted; that requester is skipped.
- Reset mid-transfer: a pending output is discarded (out_valid=0), not delivered; conv_count clears.

Decomposition:
- Shared package gray2bin_pkg:
  - Default WIDTH and NUM_REQ constants.
  - Function/typedef for the requester index.
  - Constant for conv_count saturation value.
- Sub-module gray_to_binary_core: purely combinational WIDTH-bit Gray-to-binary chain (parameter WIDTH). Instantiated once on the arbiter's muxed winner.
- Arbiter, output register, rr_ptr and counter live in the top.

Test Plan:
- Reset then single request: req_valid=4'b0001, req_gray[0]=8'hFF, out_ready=1 → next cycle out_valid=1, out_bin=8'hAA, out_id=0, rr_ptr=1.
- Value sweep on requester 2 (8'h80, 8'hC0, 8'h03, 8'h00) → out_bin = 8'hFF, 8'h80, 8'h02, 8'h00, one result per cycle, out_id=2 each time.
- All four requesting continuously, distinct Gray words, out_ready=1 → grants and out_id cycle 0,1,2,3,0 with no bubbles; conv_count=5 after five transfers.
- Backpressure: out_ready=0 for 3 cycles while FULL → req_ready=0, out_bin/out_id stable. Raising out_ready with req_valid=4'b1000 gives same-cycle drain+accept: out_valid stays 1 and out_id=3 on the next cycle.
- Reset mid-stream: assert rst while out_valid=1 → next cycle out_valid=0, conv_count=0, and the first subsequent grant goes to requester 0 when all request.
- Saturation with CNT_W=4: 17 transfers → conv_count holds at 4'hF.
